// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_pkg
// Purpose  : Shared defaults and sizing helpers for the UART receive FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_if
// Purpose  : Enqueue/dequeue handshake bundle between receiver, FIFO and
//            consumer. master = environment side, slave = FIFO side.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  logic [WIDTH-1:0]            enq_data;
  logic                        enq_valid;
  logic                        enq_ready;
  logic [WIDTH-1:0]            deq_data;
  logic                        deq_valid;
  logic                        deq_ready;
  logic [cnt_width(DEPTH)-1:0] count;

  modport master (
    output enq_data, enq_valid, deq_ready,
    input  enq_ready, deq_data, deq_valid, count
  );

  modport slave (
    input  enq_data, enq_valid, deq_ready,
    output enq_ready, deq_data, deq_valid, count
  );

endinterface
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_mem
// Purpose  : DEPTH x WIDTH register array, one write port, one async read
//            port. Contents are intentionally not reset.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             wr_en,
  input  wire logic [PTR_W-1:0] wr_addr,
  input  wire logic [WIDTH-1:0] wr_data,
  input  wire logic [PTR_W-1:0] rd_addr,
  output      logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: capture the incoming word at the write pointer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Fall-through read: head word is visible without a clock edge.
  assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : First-word fall-through byte FIFO behind the UART receiver.
//            Ready/valid flags come only from registered occupancy, so there is
//            no combinational path from enq_valid or deq_ready.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input wire logic     clk,
  input wire logic     reset,
  uart_rx_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occupancy;
  logic             not_full;
  logic             not_empty;
  logic             enq_fire;
  logic             deq_fire;
  logic [WIDTH-1:0] head_data;

  // When full, enq_ready stays low even if a dequeue happens this cycle;
  // the pending receiver word is simply taken on the following cycle.
  assign not_full  = (occupancy != FULL_CNT);
  assign not_empty = (occupancy != '0);
  assign enq_fire  = bus.enq_valid & not_full;
  assign deq_fire  = bus.deq_ready & not_empty;

  assign bus.enq_ready = not_full;
  assign bus.deq_valid = not_empty;
  assign bus.deq_data  = head_data;
  assign bus.count     = occupancy;

  // Pointers wrap by natural overflow; occupancy tracks net enq/deq.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (enq_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (deq_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq_fire, deq_fire})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  uart_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (enq_fire),
    .wr_addr (wr_ptr),
    .wr_data (bus.enq_data),
    .rd_addr (rd_ptr),
    .rd_data (head_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Self-checking bench for uart_rx_fifo: queue-based reference model
//            compared every cycle, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic started = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [WIDTH-1:0] model_q [$];

  uart_rx_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue; fire decisions come from the model's own size.
  always @(posedge clk or posedge reset) begin
    bit e;
    bit d;
    if (reset) begin
      model_q.delete();
    end else begin
      e = bus.enq_valid && (model_q.size() != DEPTH);
      d = bus.deq_ready && (model_q.size() != 0);
      if (d) void'(model_q.pop_front());
      if (e) model_q.push_back(bus.enq_data);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("m_count", 32'(bus.count), 32'(model_q.size()));
      check("m_enq_ready", 32'(bus.enq_ready), 32'(model_q.size() != DEPTH));
      check("m_deq_valid", 32'(bus.deq_valid), 32'(model_q.size() != 0));
      if (model_q.size() != 0) check("m_deq_data", 32'(bus.deq_data), 32'(model_q[0]));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit accepted;
    bus.enq_data  = '0;
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    started = 1'b1;

    // 1. Reset then idle
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_enq_ready", 32'(bus.enq_ready), 32'd1);
    check("rst_deq_valid", 32'(bus.deq_valid), 32'd0);
    repeat (10) tick();

    // 2. Single word, consumer stalled
    bus.enq_data = 8'hA5; bus.enq_valid = 1'b1;
    tick();
    bus.enq_valid = 1'b0;
    check("one_deq_valid", 32'(bus.deq_valid), 32'd1);
    check("one_count", 32'(bus.count), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("one_hold", 32'(bus.deq_data), 32'hA5);
      tick();
    end
    bus.deq_ready = 1'b1;
    tick();
    bus.deq_ready = 1'b0;
    check("one_drained", 32'(bus.count), 32'd0);

    // 3. Fill, hold ninth word, drain in order
    for (int i = 1; i <= 8; i++) begin
      bus.enq_data = 8'(i); bus.enq_valid = 1'b1;
      tick();
    end
    check("fill_count", 32'(bus.count), 32'd8);
    check("fill_enq_ready", 32'(bus.enq_ready), 32'd0);
    bus.enq_data = 8'h09;
    repeat (2) begin
      tick();
      check("full_hold_count", 32'(bus.count), 32'd8);
    end
    bus.deq_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      check("fill_order", 32'(bus.deq_data), 32'(k));
      accepted = bus.enq_valid && bus.enq_ready;
      tick();
      if (accepted) bus.enq_valid = 1'b0;
    end
    bus.deq_ready = 1'b0;
    check("fill_empty", 32'(bus.count), 32'd0);
    check("fill_src_done", 32'(bus.enq_valid), 32'd0);

    // 4. Full with simultaneous enq_valid and deq_ready
    for (int i = 0; i < 8; i++) begin
      bus.enq_data = 8'(8'h10 + i); bus.enq_valid = 1'b1;
      tick();
    end
    bus.enq_data = 8'h18; bus.deq_ready = 1'b1;
    check("full_count", 32'(bus.count), 32'd8);
    check("full_enq_ready", 32'(bus.enq_ready), 32'd0);
    tick();
    bus.deq_ready = 1'b0;
    check("full_deq_only", 32'(bus.count), 32'd7);
    check("full_new_head", 32'(bus.deq_data), 32'h11);
    tick();
    bus.enq_valid = 1'b0;
    check("full_late_enq", 32'(bus.count), 32'd8);
    bus.deq_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("full_order", 32'(bus.deq_data), 32'(8'h11 + k));
      tick();
    end
    bus.deq_ready = 1'b0;

    // 5. Streaming at occupancy 1 across several pointer wraps
    bus.enq_data = 8'h00; bus.enq_valid = 1'b1;
    tick();
    bus.deq_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.enq_data = 8'(8'h40 + i);
      check("stream_count", 32'(bus.count), 32'd1);
      check("stream_data", 32'(bus.deq_data), (i == 0) ? 32'h00 : 32'(8'h40 + i - 1));
      tick();
    end
    bus.enq_valid = 1'b0;
    check("stream_last", 32'(bus.deq_data), 32'h67);
    tick();
    bus.deq_ready = 1'b0;
    check("stream_empty", 32'(bus.count), 32'd0);

    // 6. Asynchronous reset mid-cycle with words buffered
    for (int i = 0; i < 5; i++) begin
      bus.enq_data = 8'(8'h50 + i); bus.enq_valid = 1'b1;
      tick();
    end
    bus.enq_valid = 1'b0;
    check("pre_rst_count", 32'(bus.count), 32'd5);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_deq_valid", 32'(bus.deq_valid), 32'd0);
    check("arst_enq_ready", 32'(bus.enq_ready), 32'd1);
    @(negedge clk);
    #1;
    reset = 1'b0;
    tick();
    bus.enq_data = 8'h3C; bus.enq_valid = 1'b1;
    tick();
    bus.enq_valid = 1'b0;
    check("post_rst_head", 32'(bus.deq_data), 32'h3C);
    check("post_rst_count", 32'(bus.count), 32'd1);
    bus.deq_ready = 1'b1;
    tick();
    bus.deq_ready = 1'b0;
    check("post_rst_empty", 32'(bus.count), 32'd0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
